if_stage: RTL

//  Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the PC register and drives instruction-memory address.

---
 rtl/mips_pkg.sv | 15 +
 rtl/if_stage_if.sv | 30 +++
 rtl/if_stage_pc_reg.sv | 23 ++
 rtl/if_stage.sv | 102 ++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and helpers for the MIPS pipeline: reset vector, NOP encoding,
// exception codes and the PC increment.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam int          EXC_CODE_W       = 5;
    localparam logic [EXC_CODE_W-1:0] EXC_ADEL = 5'd4;

    // Sequential successor; wraps modulo 2^32 with no carry out.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: next-PC/hazard controls and instruction memory in, PC and IF/ID
// register contents out. The fetch stage uses the slave modport.
interface if_stage_if;
    import mips_pkg::*;

    logic [31:0]           npc;
    logic                  stall;
    logic                  flush;
    logic [31:0]           imem_rdata;
    logic [31:0]           pc;
    logic [31:0]           pc4;
    logic [31:0]           imem_addr;
    logic [31:0]           id_instr;
    logic [31:0]           id_pc;
    logic [31:0]           id_pc4;
    logic                  id_valid;
    logic                  id_exc;
    logic [EXC_CODE_W-1:0] id_exc_code;

    modport master (
        output npc, stall, flush, imem_rdata,
        input  pc, pc4, imem_addr, id_instr, id_pc, id_pc4, id_valid, id_exc, id_exc_code
    );

    modport slave (
        input  npc, stall, flush, imem_rdata,
        output pc, pc4, imem_addr, id_instr, id_pc, id_pc4, id_valid, id_exc, id_exc_code
    );

endinterface

// File: rtl/if_stage_pc_reg.sv
// Program counter register: async active-low reset to the reset vector, loads npc
// whenever enabled.
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] npc,
    output logic [31:0] pc
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else if (en) begin
            pc <= npc;
        end
    end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC register, imem address and the IF/ID pipeline register.
// Optional fetch address check (AdEL) enabled by defining IF_ADDR_CHECK_EN.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
    parameter int unsigned IMEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    if_stage_if.slave   bus
);

    // An empty or misaligned fetch window cannot hold a single instruction.
    if (IMEM_BYTES == 0 || IMEM_BASE[1:0] != 2'b00) begin : g_cfg_err
        $error("if_stage: fetch window must be non-empty and word aligned");
    end

    logic [31:0] pc_p0;
    logic [31:0] pc4_p0;
    logic        adel_p0;

    pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .en    (~bus.stall | bus.flush),
        .npc   (bus.npc),
        .pc    (pc_p0)
    );

    assign pc4_p0        = pc_plus4(pc_p0);
    assign bus.pc        = pc_p0;
    assign bus.pc4       = pc4_p0;
    assign bus.imem_addr = pc_p0;

`ifdef IF_ADDR_CHECK_EN
    // 33-bit compare keeps IMEM_BASE + IMEM_BYTES from wrapping.
    localparam logic [32:0] WIN_END = {1'b0, IMEM_BASE} + 33'(IMEM_BYTES);

    assign adel_p0 = (pc_p0[1:0] != 2'b00)
                   || ({1'b0, pc_p0} <  {1'b0, IMEM_BASE})
                   || ({1'b0, pc_p0} >= WIN_END);
`else
    assign adel_p0 = 1'b0;
`endif

    // ---- IF/ID boundary ----
    logic [31:0] instr_p1;
    logic [31:0] pc_p1;
    logic [31:0] pc4_p1;
    logic        vld_p1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_p1 <= NOP_INSTR;
            pc_p1    <= 32'd0;
            pc4_p1   <= 32'd0;
            vld_p1   <= 1'b0;
        end else if (bus.flush) begin
            instr_p1 <= NOP_INSTR;
            pc_p1    <= 32'd0;
            pc4_p1   <= 32'd0;
            vld_p1   <= 1'b0;
        end else if (!bus.stall) begin
            instr_p1 <= adel_p0 ? NOP_INSTR : bus.imem_rdata;
            pc_p1    <= pc_p0;
            pc4_p1   <= pc4_p0;
            vld_p1   <= 1'b1;
        end
    end

    assign bus.id_instr = instr_p1;
    assign bus.id_pc    = pc_p1;
    assign bus.id_pc4   = pc4_p1;
    assign bus.id_valid = vld_p1;

`ifdef IF_ADDR_CHECK_EN
    logic                  exc_p1;
    logic [EXC_CODE_W-1:0] exc_code_p1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exc_p1      <= 1'b0;
            exc_code_p1 <= '0;
        end else if (bus.flush) begin
            exc_p1      <= 1'b0;
            exc_code_p1 <= '0;
        end else if (!bus.stall) begin
            exc_p1      <= adel_p0;
            exc_code_p1 <= adel_p0 ? EXC_ADEL : '0;
        end
    end

    assign bus.id_exc      = exc_p1;
    assign bus.id_exc_code = exc_code_p1;
`else
    assign bus.id_exc      = 1'b0;
    assign bus.id_exc_code = '0;
`endif

endmodule
